// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: stage occupancy
// encoding, default widths, and the ID/EX control-vector bit layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned STAT_W_DEF = 32;

  // ID/EX control vector bit positions
  localparam int unsigned CTRL_BRANCH     = 0;
  localparam int unsigned CTRL_REG_WENA   = 1;
  localparam int unsigned CTRL_MEM_RENA   = 2;
  localparam int unsigned CTRL_MEM_WENA   = 3;
  localparam int unsigned CTRL_JUMP       = 4;
  localparam int unsigned CTRL_JALR       = 5;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_MEM_TO_REG = 7;

  // True when the stage holds at least one entry (head register valid).
  function automatic logic head_valid(input stage_state_t st);
    return (st != ST_EMPTY);
  endfunction

  // True when the skid register holds an entry.
  function automatic logic skid_occupied(input stage_state_t st);
    return (st == ST_FULL);
  endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating statistics counters for a pipeline stage register:
// stall cycles, effective flushes and completed transfers.
// Only instantiated when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_stats
  import pipe_pkg::*;
#(
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_evt,
  input  logic              flush_evt,
  input  logic              xfer_evt,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
  output logic [STAT_W-1:0] xfer_cnt
);

  // Increment by one, holding at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Counter registers: cleared by reset, bumped on each qualifying event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {STAT_W{1'b0}};
      flush_cnt <= {STAT_W{1'b0}};
      xfer_cnt  <= {STAT_W{1'b0}};
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
      if (xfer_evt)  xfer_cnt  <= sat_inc(xfer_cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with a 2-entry skid
// buffer (main + skid). in_ready depends only on registered state, so the
// stage breaks the ready path while still moving one entry per cycle.
// Flush drops every held entry and any entry offered in the same cycle.
// Control bits read as zero whenever the output is not valid.
// Optional feature macro: PIPE_STAGE_STATS_EN adds saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_flush_cnt,
  output logic [STAT_W-1:0] stat_xfer_cnt
`endif
);

  stage_state_t      st;
  stage_state_t      st_next;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_valid;
  logic              skid_valid;
  logic              in_fire;
  logic              out_fire;
  logic              main_load_in;
  logic              main_load_skid;
  logic              skid_load_in;
  logic              main_ctrl_clr;
  logic              skid_ctrl_clr;

  assign main_valid = head_valid(st);
  assign skid_valid = skid_occupied(st);

  // A full stage never accepts; reset masks acceptance combinationally.
  assign in_ready  = ~skid_valid & ~rst;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{1'b0}};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next occupancy and register-load decisions; flush overrides everything.
  always_comb begin
    st_next        = st;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load_in   = 1'b0;
    main_ctrl_clr  = 1'b0;
    skid_ctrl_clr  = 1'b0;
    if (flush) begin
      st_next       = ST_EMPTY;
      main_ctrl_clr = 1'b1;
      skid_ctrl_clr = 1'b1;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (in_fire) begin
            st_next      = ST_ONE;
            main_load_in = 1'b1;
          end else begin
            st_next = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            st_next      = ST_ONE;
            main_load_in = 1'b1;
          end else if (in_fire) begin
            st_next      = ST_FULL;
            skid_load_in = 1'b1;
          end else if (out_fire) begin
            st_next       = ST_EMPTY;
            main_ctrl_clr = 1'b1;
          end else begin
            st_next = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            st_next        = ST_ONE;
            main_load_skid = 1'b1;
            skid_ctrl_clr  = 1'b1;
          end else begin
            st_next = ST_FULL;
          end
        end
        default: begin
          st_next       = ST_EMPTY;
          main_ctrl_clr = 1'b1;
          skid_ctrl_clr = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_EMPTY;
    end else begin
      st <= st_next;
    end
  end

  // Payload and control registers; data holds across flush, ctrl clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= {DATA_W{1'b0}};
      main_ctrl <= {CTRL_W{1'b0}};
      skid_data <= {DATA_W{1'b0}};
      skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      if (main_load_in) begin
        main_data <= in_data;
      end else if (main_load_skid) begin
        main_data <= skid_data;
      end
      if (main_ctrl_clr) begin
        main_ctrl <= {CTRL_W{1'b0}};
      end else if (main_load_in) begin
        main_ctrl <= in_ctrl;
      end else if (main_load_skid) begin
        main_ctrl <= skid_ctrl;
      end
      if (skid_load_in) begin
        skid_data <= in_data;
      end
      if (skid_ctrl_clr) begin
        skid_ctrl <= {CTRL_W{1'b0}};
      end else if (skid_load_in) begin
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic stall_evt;
  logic flush_evt;

  // A full stage already holds entries, so in_valid alone marks a killed input.
  assign stall_evt = out_valid & ~out_ready;
  assign flush_evt = flush & (main_valid | in_valid);

  pipe_stage_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .stall_evt (stall_evt),
    .flush_evt (flush_evt),
    .xfer_evt  (out_fire),
    .stall_cnt (stat_stall_cnt),
    .flush_cnt (stat_flush_cnt),
    .xfer_cnt  (stat_xfer_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model
// of a two-deep FIFO with flush and reset.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 8;
`ifdef PIPE_STAGE_STATS_EN
  localparam int SW = 4;
`else
  localparam int SW = 32;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [SW-1:0] stat_stall_cnt;
  logic [SW-1:0] stat_flush_cnt;
  logic [SW-1:0] stat_xfer_cnt;
  int            m_stall;
  int            m_flush;
  int            m_xfer;
`endif

  ent_t q[$];
  bit   zero_data;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .STAT_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_flush_cnt (stat_flush_cnt),
    .stat_xfer_cnt  (stat_xfer_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check outputs.
  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic [DW-1:0] id, input logic [CW-1:0] ic,
                      input logic orr);
    int sz;
    bit of_m;
    bit inf_m;
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    out_ready = orr;
    sz    = q.size();
    of_m  = (sz > 0) && orr;
    inf_m = iv && (sz < 2) && !r;
    @(posedge clk);
    if (r) begin
      q.delete();
      zero_data = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
      m_stall = 0;
      m_flush = 0;
      m_xfer  = 0;
`endif
    end else begin
`ifdef PIPE_STAGE_STATS_EN
      if ((sz > 0) && !orr && m_stall < (1 << SW) - 1) m_stall++;
      if (fl && (sz > 0 || iv) && m_flush < (1 << SW) - 1) m_flush++;
      if (of_m && m_xfer < (1 << SW) - 1) m_xfer++;
`endif
      if (fl) begin
        q.delete();
      end else begin
        if (of_m) void'(q.pop_front());
        if (inf_m) begin
          q.push_back('{d: id, c: ic});
          zero_data = 1'b0;
        end
      end
    end
    #1;
    chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("in_ready", DW'(in_ready), DW'(!r && q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
    end else begin
      chk("out_ctrl_idle", DW'(out_ctrl), '0);
      if (zero_data) chk("out_data_rst", out_data, '0);
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", DW'(stat_stall_cnt), DW'(m_stall));
    chk("flush_cnt", DW'(stat_flush_cnt), DW'(m_flush));
    chk("xfer_cnt", DW'(stat_xfer_cnt), DW'(m_xfer));
`endif
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    zero_data = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
    m_stall = 0; m_flush = 0; m_xfer = 0;
`endif
    // Reset
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 128'h99, 8'h5A, 1'b1);
    // 1: stream four entries with downstream always ready
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, DW'(i * 8'h11), CW'(i), 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    // 2: fill under backpressure, hold off third, then drain in order
    step(1'b0, 1'b0, 1'b1, 128'hA1, 8'h01, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hA2, 8'h02, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hA3, 8'h03, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hA3, 8'h03, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hA3, 8'h03, 1'b1);
    step(1'b0, 1'b0, 1'b1, 128'hA3, 8'h03, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    // 3: full with ctrl all-ones, flush while offering 0xB0
    step(1'b0, 1'b0, 1'b1, 128'hC1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hC2, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 128'hB0, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    // 4: reset while full
    step(1'b0, 1'b0, 1'b1, 128'hD1, 8'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 128'hD2, 8'h22, 1'b0);
    step(1'b1, 1'b0, 1'b1, 128'hD3, 8'h33, 1'b1);
    step(1'b1, 1'b0, 1'b1, 128'hD4, 8'h44, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    // 5: randomized traffic against the model
    for (int n = 0; n < 10000; n++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = CW'($urandom());
      step($urandom_range(0, 499) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0, rd, rc, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
